// File: rtl/alu_nibble_seq_pkg.sv
// Shared constants for the nibble-serial ALU controller and its 4-bit slice:
// opcodes, controller state encoding and the slice width.
package alu_nibble_seq_pkg;

  localparam int NIB_W = 4;

  localparam logic [2:0] OP_NOTA = 3'b000;
  localparam logic [2:0] OP_NOTB = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu4_slice.sv
// Combinational 4-bit ALU slice built from gate primitives.
// SUB relies on the caller presenting the inverted B nibble and the carry-in chain.
module alu4_slice
  import alu_nibble_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             cin_i,
  input  logic [2:0]       op_i,
  output logic [NIB_W-1:0] y_o,
  output logic             cout_o
);

  wire [NIB_W-1:0] nota_s;
  wire [NIB_W-1:0] notb_s;
  wire [NIB_W-1:0] and_s;
  wire [NIB_W-1:0] or_s;
  wire [NIB_W-1:0] xor_s;
  wire [NIB_W-1:0] xnor_s;
  wire [NIB_W-1:0] sum_s;
  wire [NIB_W-1:0] prop_s;
  wire [NIB_W:0]   carry_s;

  assign carry_s[0] = cin_i;

  for (genvar i = 0; i < NIB_W; i++) begin : g_bit
    not  u_nota (nota_s[i], a_i[i]);
    not  u_notb (notb_s[i], b_i[i]);
    and  u_and  (and_s[i], a_i[i], b_i[i]);
    or   u_or   (or_s[i], a_i[i], b_i[i]);
    xor  u_xor  (xor_s[i], a_i[i], b_i[i]);
    xnor u_xnor (xnor_s[i], a_i[i], b_i[i]);
    xor  u_sum  (sum_s[i], xor_s[i], carry_s[i]);
    and  u_prop (prop_s[i], xor_s[i], carry_s[i]);
    or   u_cout (carry_s[i+1], and_s[i], prop_s[i]);
  end

  // Result select: only the adder path produces a carry-out
  always_comb begin
    y_o    = '0;
    cout_o = 1'b0;
    case (op_i)
      OP_NOTA: y_o = nota_s;
      OP_NOTB: y_o = notb_s;
      OP_AND:  y_o = and_s;
      OP_OR:   y_o = or_s;
      OP_XOR:  y_o = xor_s;
      OP_XNOR: y_o = xnor_s;
      OP_ADD, OP_SUB: begin
        y_o    = sum_s;
        cout_o = carry_s[NIB_W];
      end
      default: begin
        y_o    = '0;
        cout_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// Word-wide ALU that sequences one 4-bit slice over the operand, least-significant nibble first.
// Flags c/n/z/v are generated only with ALU_NIBBLE_SEQ_FLAGS_EN defined; otherwise they are tied to 0.
module alu_nibble_seq
  import alu_nibble_seq_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIB_W * NIBBLES,
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         c,
  output logic         n,
  output logic         z,
  output logic         v
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [2:0]                    op_q, op_d;
  logic [NIBBLES-1:0][NIB_W-1:0] a_q, a_d;
  logic [NIBBLES-1:0][NIB_W-1:0] b_q, b_d;
  logic [NIBBLES-1:0][NIB_W-1:0] result_q, result_d;
  logic                          carry_q, carry_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic [NIB_W-1:0] a_nib_s;
  logic [NIB_W-1:0] b_nib_s;
  logic [NIB_W-1:0] y_s;
  logic             cout_s;
  logic             last_s;

  // SUB runs through the adder as A + ~B + 1, so B is inverted per nibble here
  assign a_nib_s = a_q[idx_q];
  assign b_nib_s = (op_q == OP_SUB) ? ~b_q[idx_q] : b_q[idx_q];
  assign last_s  = (idx_q == LAST_IDX);

  alu4_slice u_slice (
    .a_i    (a_nib_s),
    .b_i    (b_nib_s),
    .cin_i  (carry_q),
    .op_i   (op_q),
    .y_o    (y_s),
    .cout_o (cout_s)
  );

  // Controller next-state: accept in IDLE, one nibble per RUN cycle, single DONE cycle
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          carry_d = (op == OP_SUB);
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        result_d[idx_q] = y_s;
        carry_d         = cout_s;
        busy_d          = 1'b1;
        if (last_s) begin
          idx_d   = '0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller registers; reset abandons any operation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      op_q     <= 3'b000;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
  logic c_q, c_d;
  logic n_q, n_d;
  logic z_q, z_d;
  logic v_q, v_d;
  logic zacc_q, zacc_d;
  logic nib_zero_s;

  assign nib_zero_s = (y_s == '0);

  // Flag next-state: zero accumulates per nibble, the rest resolve on the top nibble
  always_comb begin
    c_d    = c_q;
    n_d    = n_q;
    z_d    = z_q;
    v_d    = v_q;
    zacc_d = zacc_q;
    if ((state_q == ST_IDLE) && start) begin
      zacc_d = 1'b1;
    end else if (state_q == ST_RUN) begin
      zacc_d = zacc_q & nib_zero_s;
      if (last_s) begin
        c_d = is_arith(op_q) & cout_s;
        n_d = y_s[NIB_W-1];
        z_d = zacc_q & nib_zero_s;
        v_d = is_arith(op_q)
              & (a_nib_s[NIB_W-1] == b_nib_s[NIB_W-1])
              & (y_s[NIB_W-1] != a_nib_s[NIB_W-1]);
      end else begin
        c_d = c_q;
      end
    end else begin
      zacc_d = zacc_q;
    end
  end

  // Flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_q    <= 1'b0;
      n_q    <= 1'b0;
      z_q    <= 1'b0;
      v_q    <= 1'b0;
      zacc_q <= 1'b0;
    end else begin
      c_q    <= c_d;
      n_q    <= n_d;
      z_q    <= z_d;
      v_q    <= v_d;
      zacc_q <= zacc_d;
    end
  end

  assign c = c_q;
  assign n = n_q;
  assign z = z_q;
  assign v = v_q;
`else
  assign c = 1'b0;
  assign n = 1'b0;
  assign z = 1'b0;
  assign v = 1'b0;
`endif

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq: directed cases with literal expectations plus
// randomized operations checked every cycle against a word-level model.
module tb_alu_nibble_seq;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;
`ifdef ALU_NIBBLE_SEQ_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         n;
    logic         z;
    logic         v;
  } exp_t;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic         start   = 1'b0;
  logic [2:0]   op      = 3'd0;
  logic [W-1:0] a       = '0;
  logic [W-1:0] b       = '0;
  logic         busy, done, c, n, z, v;
  logic [W-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  logic m_active = 1'b0;
  int   m_age    = 0;
  exp_t m_exp    = '0;

  alu_nibble_seq #(.NIBBLES(NIB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .c       (c),
    .n       (n),
    .z       (z),
    .v       (v)
  );

  always #5 clk = ~clk;

  // Word-level reference: plain arithmetic on the full operands
  function automatic exp_t model_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t       e;
    logic [W:0] s;
    e = '0;
    s = '0;
    case (o)
      3'd0: e.r = ~x;
      3'd1: e.r = ~y;
      3'd2: e.r = x & y;
      3'd3: e.r = x | y;
      3'd4: e.r = x ^ y;
      3'd5: e.r = ~(x ^ y);
      3'd6: begin
        s   = {1'b0, x} + {1'b0, y};
        e.r = s[W-1:0];
        e.c = s[W];
        e.v = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]);
      end
      default: begin
        s   = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        e.r = s[W-1:0];
        e.c = s[W];
        e.v = (x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]);
      end
    endcase
    e.n = e.r[W-1];
    e.z = (e.r == '0);
    e.c = e.c & FLAGS_EN;
    e.n = e.n & FLAGS_EN;
    e.z = e.z & FLAGS_EN;
    e.v = e.v & FLAGS_EN;
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] r, input logic ec, input logic en,
                              input logic ez, input logic ev);
    exp_t e;
    e.r = r;
    e.c = ec & FLAGS_EN;
    e.n = en & FLAGS_EN;
    e.z = ez & FLAGS_EN;
    e.v = ev & FLAGS_EN;
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model timeline: age counts clock edges since the accepting edge
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active <= 1'b0;
      m_age    <= 0;
    end else if (start && (!m_active || m_age > NIB)) begin
      m_active <= 1'b1;
      m_age    <= 0;
      m_exp    <= model_op(op, a, b);
    end else if (m_age < 1000) begin
      m_age <= m_age + 1;
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_busy",   32'(busy),   32'(0));
      check("rst_done",   32'(done),   32'(0));
      check("rst_result", 32'(result), 32'(0));
      check("rst_flags",  32'({c, n, z, v}), 32'(0));
    end else begin
      check("busy", 32'(busy), 32'(m_active && (m_age <= NIB)));
      check("done", 32'(done), 32'(m_active && (m_age == NIB)));
      if (m_active && (m_age == NIB)) begin
        check("m_result", 32'(result), 32'(m_exp.r));
        check("m_flags",  32'({c, n, z, v}), 32'({m_exp.c, m_exp.n, m_exp.z, m_exp.v}));
      end
    end
  end

  // Caller sits at a negedge; returns at the negedge after done, ready for a back-to-back start
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit lit, input exp_t le, input bit hammer, input string nm);
    int j;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    j     = 0;
    start = hammer;
    a     = W'($urandom);
    b     = W'($urandom);
    op    = 3'($urandom);
    while ((done !== 1'b1) && (j < 20)) begin
      @(negedge clk);
      j++;
      a  = W'($urandom);
      b  = W'($urandom);
      op = 3'($urandom);
    end
    check({nm, "_latency"}, 32'(j), 32'(NIB));
    if (lit) begin
      check({nm, "_result"}, 32'(result), 32'(le.r));
      check({nm, "_c"}, 32'(c), 32'(le.c));
      check({nm, "_n"}, 32'(n), 32'(le.n));
      check({nm, "_z"}, 32'(z), 32'(le.z));
      check({nm, "_v"}, 32'(v), 32'(le.v));
    end
    @(negedge clk);
    start = 1'b0;
    check({nm, "_done_once"}, 32'(done), 32'(0));
    check({nm, "_idle"}, 32'(busy), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);

    run_op(3'b110, 16'h00FF, 16'h0001, 1'b1, mk(16'h0100, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, "add_carry_nib");
    run_op(3'b111, 16'h1234, 16'h1234, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0, "sub_equal");
    run_op(3'b110, 16'hFFFF, 16'h0001, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0, "add_wrap");
    run_op(3'b110, 16'h7FFF, 16'h0001, 1'b1, mk(16'h8000, 1'b0, 1'b1, 1'b0, 1'b1), 1'b0, "add_ovf");
    run_op(3'b111, 16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0, "sub_ovf");
    run_op(3'b100, 16'hA5A5, 16'hFFFF, 1'b1, mk(16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, "xor");
    run_op(3'b000, 16'h0F0F, 16'h1234, 1'b1, mk(16'hF0F0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, "nota");
    run_op(3'b110, 16'h0003, 16'h0004, 1'b1, mk(16'h0007, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, "start_ignored");

    // Reset after two nibbles have been written
    start = 1'b1;
    op    = 3'b110;
    a     = 16'h1111;
    b     = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("partial_low", 32'(result[7:0]), 32'(8'h22));
    #2 reset_n = 1'b0;
    #1;
    check("midrun_busy",   32'(busy),   32'(0));
    check("midrun_done",   32'(done),   32'(0));
    check("midrun_result", 32'(result), 32'(0));
    check("midrun_flags",  32'({c, n, z, v}), 32'(0));
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'(0));
    run_op(3'b011, 16'h1200, 16'h0034, 1'b1, mk(16'h1234, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, "post_rst");

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = pick();
      rb = pick();
      run_op(3'($urandom_range(0, 7)), ra, rb, 1'b0, '0, ($urandom_range(0, 3) == 0), "rand");
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
